// File: rtl/bbox_accum.sv
// Bounding-box accumulator: merges per-slot boxes over a frame, then dumps
// every occupied slot in ascending order with ready/valid backpressure.
module bbox_accum #(
  parameter int XW   = 7,
  parameter int YW   = 6,
  parameter int NOBJ = 4,
  parameter int IDW  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    frame_end,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDW-1:0]          in_id,
  input  logic [2*XW+2*YW-1:0]    in_box,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDW-1:0]          out_id,
  output logic [2*XW+2*YW-1:0]    out_box,
  output logic                    dump_done,
  output logic [NOBJ-1:0]         occupied,
  output logic                    id_err
);

  localparam int BW = 2*XW + 2*YW;

  typedef enum logic {ACCUM, DUMP} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     box_q [NOBJ];
  logic [BW-1:0]     box_d [NOBJ];
  logic [NOBJ-1:0]   occ_q, occ_d;
  logic              id_err_q, id_err_d;
  logic [IDW-1:0]    idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [IDW-1:0]    out_id_q, out_id_d;
  logic [BW-1:0]     out_box_q, out_box_d;
  logic              dump_done_q, dump_done_d;
  logic              accept;
  logic              id_ok;

  // Field-wise union of two boxes: min of the corner origin, max of the far corner.
  function automatic logic [BW-1:0] merge_box(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [XW-1:0] ax0, axn, bx0, bxn;
    logic [YW-1:0] ay0, ayn, by0, byn;
    {ax0, ay0, axn, ayn} = a;
    {bx0, by0, bxn, byn} = b;
    return {(bx0 < ax0) ? bx0 : ax0,
            (by0 < ay0) ? by0 : ay0,
            (bxn > axn) ? bxn : axn,
            (byn > ayn) ? byn : ayn};
  endfunction

  assign accept   = in_valid && (state_q == ACCUM);
  assign id_ok    = ({1'b0, in_id} < (IDW+1)'(NOBJ));
  assign in_ready = (state_q == ACCUM);

  // Next-state: accumulate/clear in ACCUM, scan slots in DUMP. Output beat
  // registers are loaded from the next-state view so they align with idx_q.
  always_comb begin
    state_d     = state_q;
    box_d       = box_q;
    occ_d       = occ_q;
    id_err_d    = id_err_q;
    idx_d       = idx_q;
    dump_done_d = 1'b0;
    out_valid_d = 1'b0;
    out_id_d    = '0;
    out_box_d   = '0;

    if (state_q == ACCUM) begin
      if (frame_start) begin
        occ_d    = '0;
        id_err_d = 1'b0;
      end
      if (accept) begin
        if (!id_ok) begin
          id_err_d = 1'b1;
        end else begin
          for (int unsigned i = 0; i < NOBJ; i++) begin
            if (in_id == IDW'(i)) begin
              box_d[i] = occ_d[i] ? merge_box(box_q[i], in_box) : in_box;
              occ_d[i] = 1'b1;
            end
          end
        end
      end
      if (frame_end) begin
        state_d = DUMP;
        idx_d   = '0;
      end
    end else begin
      if (!out_valid_q || out_ready) begin
        if (idx_q == IDW'(NOBJ-1)) begin
          state_d     = ACCUM;
          dump_done_d = 1'b1;
          occ_d       = '0;
          idx_d       = '0;
          for (int unsigned i = 0; i < NOBJ; i++) begin
            box_d[i] = '0;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end

    if (state_d == DUMP) begin
      for (int unsigned i = 0; i < NOBJ; i++) begin
        if (idx_d == IDW'(i) && occ_d[i]) begin
          out_valid_d = 1'b1;
          out_id_d    = idx_d;
          out_box_d   = box_d[i];
        end
      end
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      box_q       <= '{default: '0};
      occ_q       <= '0;
      id_err_q    <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_box_q   <= '0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      box_q       <= box_d;
      occ_q       <= occ_d;
      id_err_q    <= id_err_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_box_q   <= out_box_d;
      dump_done_q <= dump_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_box   = out_box_q;
  assign dump_done = dump_done_q;
  assign occupied  = occ_q;
  assign id_err    = id_err_q;

endmodule
